pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (Z, rs/rt values, immediates).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the control payload (rf_we, dmem_wr_ena, mux selects, aluc).
REQ-003 SHALL have parameter SKID, default 1: 1 selects a 2-entry skid buffer, 0 selects a single-entry register.
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush  input  1  discard all held entries (branch/exception squash).
REQ-009 in_valid  input  1  upstream stage presents an entry.
REQ-010 in_ready  output  1  this stage accepts an entry this cycle.
REQ-011 in_data  input  DATA_W  upstream datapath payload.
REQ-012 in_ctrl  input  CTRL_W  upstream control payload.
REQ-013 out_valid  output  1  downstream entry valid.
REQ-014 out_ready  input  1  downstream stage consumes the entry (de-asserted = stall).
REQ-015 out_data  output  DATA_W  datapath payload to downstream.
REQ-016 out_ctrl  output  CTRL_W  control payload to downstream.
REQ-017 occupancy  output  2  number of held entries, 0..2.
REQ-018 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Transfers SHALL occur only on cycles where valid and ready are both 1 on the same side.
REQ-020 With SKID=1, the block SHALL have states EMPTY, FULL and SKID, and in_ready SHALL be registered, equal to (state != SKID).
REQ-021 From EMPTY: in_valid -> FULL, with main <= in.
REQ-022 From FULL: in_valid&out_ready -> FULL (main <= in); in_valid&!out_ready -> SKID (skid <= in); !in_valid&out_ready -> EMPTY; otherwise hold.
REQ-023 From SKID: out_ready -> FULL (main <= skid); otherwise hold; no input is accepted in SKID.
REQ-024 With SKID=0, in_ready SHALL be combinational, equal to out_ready | !out_valid, and the SKID state SHALL be unreachable.
REQ-025 Latency SHALL be 1 cycle from accepted input to out_valid when the block is EMPTY or FULL draining.
REQ-026 out_valid SHALL equal (state != EMPTY); out_data/out_ctrl SHALL always present the main entry.
REQ-027 out_ctrl SHALL be all-zero whenever out_valid=0, so that a bubble is inert downstream; out_data SHALL hold its last value.
REQ-028 Entries SHALL leave strictly in arrival order; none SHALL be duplicated or dropped except by flush or rst.
REQ-029 flush SHALL take priority over every transfer: next state EMPTY, both entries discarded, and in_data accepted in the same cycle dropped.
REQ-030 occupancy SHALL be 0/1/2 for EMPTY/FULL/SKID.
REQ-031 stall_cnt SHALL increment on each cycle with out_valid&!out_ready, saturate at 2^CNT_W-1, and be unaffected by flush.

Reset
REQ-032 rst SHALL set state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid entry=0, occupancy=0, stall_cnt=0, and in_ready=1 from the cycle after reset.
REQ-033 rst asserted mid-operation SHALL discard held entries identically to flush, and additionally SHALL clear stall_cnt.

Structure
REQ-034 The state encoding (EMPTY=0, FULL=1, SKID=2) and occupancy constants SHALL live in shared package pipe_pkg.
REQ-035 The saturating counter SHALL be sub-module pipe_sat_cnt (parameter CNT_W; ports inc, clr, count).
REQ-036 All IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers SHALL be instances of this block, with payloads concatenated into in_data/in_ctrl.

Verification
REQ-037 After rst, drive in_valid=1, in_data=0x0000_0011, in_ctrl=0x81, out_ready=1 -> out_valid=1, out_data=0x11, out_ctrl=0x81 after 1 cycle.
REQ-038 With SKID=1, send entries 0xA, 0xB, 0xC with out_ready=0 -> occupancy reaches 2, in_ready=0, and 0xC is held upstream; raise out_ready -> output order 0xA, 0xB, 0xC.
REQ-039 With occupancy=2, assert flush together with in_valid=1 and in_data=0xD -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, and 0xD is never output.
REQ-040 Hold out_valid=1 with out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt=0xFFFF; a following flush leaves it at 0xFFFF, and rst clears it to 0.
REQ-041 With SKID=0, stream 8 entries with out_ready toggling every cycle -> in_ready equals out_ready|!out_valid every cycle, and all 8 entries are output in order.
REQ-042 Assert rst in the SKID state -> next cycle occupancy=0, out_valid=0, out_data=0, and in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and
// the occupancy value reported for each state.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd1;
  localparam logic [1:0] OCC_SKID  = 2'd2;

  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ST_FULL: occ_of = OCC_FULL;
      ST_SKID: occ_of = OCC_SKID;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr)
      r_cnt <= '0;
    else if (inc && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign count = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// squash input and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            r_state, w_state_nx;
  logic [DATA_W-1:0] r_main_data, r_skid_data, w_main_data_nx, w_skid_data_nx;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl, w_main_ctrl_nx, w_skid_ctrl_nx;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_in_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: decided from the next state so upstream never
      // sees a combinational path from out_ready.
      logic r_rdy;
      always_ff @(posedge clk) begin
        if (rst) r_rdy <= 1'b1;
        else     r_rdy <= (w_state_nx != ST_SKID);
      end
      assign w_in_ready = r_rdy;
    end else begin : g_noskid
      assign w_in_ready = out_ready | ~w_out_valid;
    end
  endgenerate

  always_comb begin
    w_state_nx     = r_state;
    w_main_data_nx = r_main_data;
    w_main_ctrl_nx = r_main_ctrl;
    w_skid_data_nx = r_skid_data;
    w_skid_ctrl_nx = r_skid_ctrl;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nx     = ST_FULL;
          w_main_data_nx = in_data;
          w_main_ctrl_nx = in_ctrl;
        end
      end
      ST_FULL: begin
        if (w_in_fire && out_ready) begin
          w_main_data_nx = in_data;
          w_main_ctrl_nx = in_ctrl;
        end else if (w_in_fire) begin
          // Only reachable with the skid buffer: without it ready is out_ready here.
          w_state_nx     = ST_SKID;
          w_skid_data_nx = in_data;
          w_skid_ctrl_nx = in_ctrl;
        end else if (out_ready) begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          w_state_nx     = ST_FULL;
          w_main_data_nx = r_skid_data;
          w_main_ctrl_nx = r_skid_ctrl;
        end
      end
      default: w_state_nx = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nx     = ST_EMPTY;
      w_main_data_nx = r_main_data;
      w_main_ctrl_nx = r_main_ctrl;
      w_skid_data_nx = r_skid_data;
      w_skid_ctrl_nx = r_skid_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_main_data <= w_main_data_nx;
      r_main_ctrl <= w_main_ctrl_nx;
      r_skid_data <= w_skid_data_nx;
      r_skid_ctrl <= w_skid_ctrl_nx;
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (w_out_valid & ~out_ready),
    .count (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  // Bubbles carry zero control so downstream write enables stay off.
  assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-buffer instance for ordering/flush/reset/stall counter,
// plain-register instance for combinational ready streaming.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        rst1, flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] in_data1, out_data1;
  logic [7:0]  in_ctrl1, out_ctrl1;
  logic [1:0]  occ1;
  logic [15:0] stall1;

  // SKID=0 instance
  logic        rst0, flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  logic [7:0]  in_ctrl0, out_ctrl0;
  logic [1:0]  occ0;
  logic [3:0]  stall0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_ctrl(in_ctrl1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1), .stall_cnt(stall1)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst0), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0), .stall_cnt(stall0)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   sent, recv, c;
    logic m_valid, exp_rdy, in_f, out_f;

    rst1 = 1; flush1 = 0; in_valid1 = 0; in_data1 = '0; in_ctrl1 = '0; out_ready1 = 0;
    rst0 = 1; flush0 = 0; in_valid0 = 0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 0;
    tick(); tick();
    rst1 = 0; rst0 = 0;

    // Reset state
    chk("rst_vld",   out_valid1, 0);
    chk("rst_ctrl",  out_ctrl1,  0);
    chk("rst_data",  out_data1,  0);
    chk("rst_occ",   occ1,       0);
    chk("rst_stall", stall1,     0);
    chk("rst_rdy",   in_ready1,  1);
    chk("rst0_occ",  occ0,       0);
    chk("rst0_stall", stall0,    0);

    // Single transfer, 1-cycle latency
    in_valid1 = 1; in_data1 = 32'h0000_0011; in_ctrl1 = 8'h81; out_ready1 = 1;
    tick();
    chk("lat_vld",  out_valid1, 1);
    chk("lat_data", out_data1,  32'h11);
    chk("lat_ctrl", out_ctrl1,  8'h81);
    chk("lat_occ",  occ1,       1);
    in_valid1 = 0;
    tick();
    chk("drain_vld",  out_valid1, 0);
    chk("drain_ctrl", out_ctrl1,  0);
    chk("drain_data", out_data1,  32'h11);

    // Skid fill and ordered drain
    out_ready1 = 0; in_valid1 = 1; in_data1 = 32'hA; in_ctrl1 = 8'h0A;
    tick();
    chk("sk_a_occ", occ1, 1);
    chk("sk_a_rdy", in_ready1, 1);
    in_data1 = 32'hB; in_ctrl1 = 8'h0B;
    tick();
    chk("sk_b_occ",  occ1, 2);
    chk("sk_b_rdy",  in_ready1, 0);
    chk("sk_b_data", out_data1, 32'hA);
    in_data1 = 32'hC; in_ctrl1 = 8'h0C;
    tick();
    chk("sk_c_occ",  occ1, 2);
    chk("sk_c_data", out_data1, 32'hA);
    chk("sk_c_ctrl", out_ctrl1, 8'h0A);
    out_ready1 = 1;
    tick();
    chk("sk_d1_data", out_data1, 32'hB);
    chk("sk_d1_occ",  occ1, 1);
    chk("sk_d1_rdy",  in_ready1, 1);
    tick();
    chk("sk_d2_data", out_data1, 32'hC);
    chk("sk_d2_ctrl", out_ctrl1, 8'h0C);
    in_valid1 = 0;
    tick();
    chk("sk_end_vld", out_valid1, 0);
    chk("sk_stall",   stall1, 2);

    // Flush in skid state with a simultaneous input
    out_ready1 = 0; in_valid1 = 1; in_data1 = 32'h1; in_ctrl1 = 8'h11;
    tick();
    in_data1 = 32'h2; in_ctrl1 = 8'h22;
    tick();
    chk("fl_pre_occ", occ1, 2);
    flush1 = 1; in_data1 = 32'hD; in_ctrl1 = 8'hDD;
    tick();
    flush1 = 0; in_valid1 = 0;
    chk("fl_vld",  out_valid1, 0);
    chk("fl_ctrl", out_ctrl1,  0);
    chk("fl_occ",  occ1,       0);
    chk("fl_rdy",  in_ready1,  1);
    out_ready1 = 1;
    tick();
    chk("fl_no_d",  out_valid1, 0);
    chk("fl_stall", stall1, 4);

    // Reset while in skid state
    out_ready1 = 0; in_valid1 = 1; in_data1 = 32'h5; in_ctrl1 = 8'h55;
    tick();
    in_data1 = 32'h6; in_ctrl1 = 8'h66;
    tick();
    chk("rs_pre_occ", occ1, 2);
    rst1 = 1; in_valid1 = 0;
    tick();
    rst1 = 0;
    chk("rs_occ",   occ1,       0);
    chk("rs_vld",   out_valid1, 0);
    chk("rs_data",  out_data1,  0);
    chk("rs_rdy",   in_ready1,  1);
    chk("rs_stall", stall1,     0);

    // Stall counter saturation
    in_valid1 = 1; in_data1 = 32'h77; in_ctrl1 = 8'h07; out_ready1 = 0;
    tick();
    in_valid1 = 0;
    repeat (70000) tick();
    chk("sat_stall", stall1, 16'hFFFF);
    flush1 = 1;
    tick();
    flush1 = 0;
    chk("sat_fl_stall", stall1, 16'hFFFF);
    chk("sat_fl_vld",   out_valid1, 0);
    tick();
    chk("sat_idle_stall", stall1, 16'hFFFF);
    rst1 = 1;
    tick();
    rst1 = 0;
    chk("sat_rst_stall", stall1, 0);

    // Plain-register streaming with toggling out_ready
    sent = 0; recv = 0; c = 0; m_valid = 0;
    while (recv < 8 && c < 40) begin
      in_valid0  = (sent < 8);
      in_data0   = 32'h100 + sent;
      in_ctrl0   = 8'(sent + 1);
      out_ready0 = ~c[0];
      #1;
      exp_rdy = out_ready0 | ~m_valid;
      chk("ns_rdy", in_ready0, exp_rdy);
      chk("ns_vld", out_valid0, m_valid);
      chk("ns_occ", occ0, {1'b0, m_valid});
      in_f  = in_valid0 & exp_rdy;
      out_f = m_valid & out_ready0;
      if (out_f) begin
        chk("ns_data", out_data0, 32'h100 + recv);
        chk("ns_ctrl", out_ctrl0, 8'(recv + 1));
        recv++;
      end
      tick();
      if (in_f) begin
        m_valid = 1;
        sent++;
      end else if (out_f) begin
        m_valid = 0;
      end
      c++;
    end
    chk("ns_count", recv, 8);
    in_valid0 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
